// File: rtl/mem_test_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_test_master
// Purpose  : Built-in memory test master. Runs a strided burst of 16-bit word
//            accesses over a 4-phase REQ/ACK handshake. Write mode fills the
//            memory with an incrementing pattern. Verify mode reads the
//            pattern back, counts mismatches and records the first failing
//            address. Any single ACK wait longer than TIMEOUT cycles aborts
//            the burst.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT        max cycles waiting for one ACK edge before abort (>= 1)
// Ports
//   CLK            clock, all logic on posedge
//   nRST           synchronous active-low reset
//   START          command strobe, sampled only while idle
//   OP             1 = write burst, 0 = verify burst
//   BASE           byte address of word 0
//   COUNT          number of words (0 = no-op)
//   SEED           data for word 0
//   BUSY           high while a burst is in flight
//   DONE           one-cycle pulse at burst end (normal or abort)
//   ERR_CNT        saturating verify mismatch count
//   FIRST_ERR_ADDR address of first mismatch, 0 if none
//   TIMEOUT_ERR    sticky handshake timeout flag, cleared by next START
//   M_ADDR/M_WDATA/M_REQ/M_WEN  memory request side
//   M_RDATA/M_ACK               memory response side
// ============================================================================
module mem_test_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        START,
  input  logic        OP,
  input  logic [15:0] BASE,
  input  logic [15:0] COUNT,
  input  logic [15:0] SEED,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] ERR_CNT,
  output logic [15:0] FIRST_ERR_ADDR,
  output logic        TIMEOUT_ERR,
  output logic [15:0] M_ADDR,
  output logic [15:0] M_WDATA,
  input  logic [15:0] M_RDATA,
  output logic        M_REQ,
  output logic        M_WEN,
  input  logic        M_ACK
);

  // The wait counter only has to hold 0..TIMEOUT-1: the cycle that would
  // reach TIMEOUT is the cycle that aborts.
  localparam int                  C_WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2,
    S_FIN     = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_k, w_k_nxt;
  logic [15:0]         r_count, w_count_nxt;
  logic [C_WAIT_W-1:0] r_wait, w_wait_nxt;
  logic [15:0]         r_addr, w_addr_nxt;
  logic [15:0]         r_wdata, w_wdata_nxt;
  logic                r_req, w_req_nxt;
  logic                r_wen, w_wen_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [15:0]         r_err_cnt, w_err_cnt_nxt;
  logic [15:0]         r_first_err, w_first_err_nxt;
  logic                r_tmo, w_tmo_nxt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_count     <= '0;
      r_wait      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req       <= 1'b0;
      r_wen       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_tmo       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_count     <= w_count_nxt;
      r_wait      <= w_wait_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_req       <= w_req_nxt;
      r_wen       <= w_wen_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_first_err <= w_first_err_nxt;
      r_tmo       <= w_tmo_nxt;
    end
  end

  // Next-state logic also produces the next value of every registered output,
  // so the outputs change on the same edge as the state they belong to.
  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_count_nxt     = r_count;
    w_wait_nxt      = '0;       // cleared on every state entry
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_req_nxt       = r_req;
    w_wen_nxt       = r_wen;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_err_cnt_nxt   = r_err_cnt;
    w_first_err_nxt = r_first_err;
    w_tmo_nxt       = r_tmo;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_k_nxt         = '0;
          w_count_nxt     = COUNT;
          w_addr_nxt      = BASE;
          w_wdata_nxt     = SEED;
          w_wen_nxt       = OP;
          w_err_cnt_nxt   = '0;
          w_first_err_nxt = '0;
          w_tmo_nxt       = 1'b0;
          if (COUNT == 16'd0) begin
            w_state_nxt = S_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ASSERT;
            w_req_nxt   = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end
      end

      S_ASSERT: begin
        if (M_ACK) begin
          // Read data is updated on the same edge ACK rises, so it is valid
          // here. M_WDATA holds the expected pattern in both modes.
          if (!r_wen && (M_RDATA != r_wdata)) begin
            if (r_err_cnt != 16'hFFFF) begin
              w_err_cnt_nxt = r_err_cnt + 16'd1;
            end
            if (r_err_cnt == 16'd0) begin
              w_first_err_nxt = r_addr;
            end
          end
          w_state_nxt = S_RELEASE;
          w_req_nxt   = 1'b0;
        end else if (r_wait == C_WAIT_LAST) begin
          w_state_nxt = S_FIN;
          w_req_nxt   = 1'b0;
          w_tmo_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end

      S_RELEASE: begin
        if (!M_ACK) begin
          if (r_k == r_count - 16'd1) begin
            w_state_nxt = S_FIN;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_k_nxt     = r_k + 16'd1;
            w_addr_nxt  = r_addr + 16'd2;
            w_wdata_nxt = r_wdata + 16'd1;
            w_state_nxt = S_ASSERT;
            w_req_nxt   = 1'b1;
          end
        end else if (r_wait == C_WAIT_LAST) begin
          w_state_nxt = S_FIN;
          w_tmo_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign BUSY           = r_busy;
  assign DONE           = r_done;
  assign ERR_CNT        = r_err_cnt;
  assign FIRST_ERR_ADDR = r_first_err;
  assign TIMEOUT_ERR    = r_tmo;
  assign M_ADDR         = r_addr;
  assign M_WDATA        = r_wdata;
  assign M_REQ          = r_req;
  assign M_WEN          = r_wen;

endmodule
`default_nettype wire

// File: tb/tb_mem_test_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_test_master
// Purpose  : Self-checking bench for mem_test_master with a 64 KB word memory
//            model that can also hold ACK low forever or stick ACK high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_test_master;

  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        START, OP;
  logic [15:0] BASE, COUNT, SEED;
  logic        BUSY, DONE, TIMEOUT_ERR;
  logic [15:0] ERR_CNT, FIRST_ERR_ADDR;
  logic [15:0] M_ADDR, M_WDATA;
  logic [15:0] M_RDATA;
  logic        M_REQ, M_WEN, M_ACK;

  always #5 CLK = ~CLK;

  mem_test_master #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .OP(OP), .BASE(BASE),
    .COUNT(COUNT), .SEED(SEED), .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT),
    .FIRST_ERR_ADDR(FIRST_ERR_ADDR), .TIMEOUT_ERR(TIMEOUT_ERR),
    .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .M_REQ(M_REQ),
    .M_WEN(M_WEN), .M_ACK(M_ACK)
  );

  // ---------------- memory model ----------------
  // mode 0: normal, 1: never acknowledges, 2: ACK never falls once raised
  bit   [15:0] mem [32768];
  logic        mem_ack;
  logic [15:0] mem_rdata;
  int          mem_mode;
  logic [31:0] obs_q[$];   // observed writes {addr, data}
  logic [31:0] exp_q[$];   // expected writes {addr, data}

  assign M_ACK   = mem_ack;
  assign M_RDATA = mem_rdata;

  always @(posedge CLK) begin
    if (!nRST) begin
      mem_ack   <= 1'b0;
      mem_rdata <= 16'h0000;
    end else if (mem_mode == 1) begin
      mem_ack <= 1'b0;
    end else if (M_REQ && !mem_ack) begin
      mem_ack <= 1'b1;
      if (M_WEN) begin
        mem[M_ADDR[15:1]] <= M_WDATA;
        obs_q.push_back({M_ADDR, M_WDATA});
      end else begin
        mem_rdata <= mem[M_ADDR[15:1]];
      end
    end else if (!M_REQ && mem_ack && mem_mode != 2) begin
      mem_ack <= 1'b0;
    end
  end

  // ---------------- handshake monitor ----------------
  int          req_rises = 0;
  int          req_hi    = 0;
  int          viol      = 0;
  logic        prev_req  = 1'b0;
  logic [15:0] prev_addr = 16'h0, prev_wdata = 16'h0;
  logic        prev_wen  = 1'b0;

  always @(posedge CLK) begin
    if (M_REQ && !prev_req) begin
      req_rises <= req_rises + 1;
      if (mem_ack) viol <= viol + 1;
    end
    if (M_REQ && prev_req &&
        (M_ADDR != prev_addr || M_WDATA != prev_wdata || M_WEN != prev_wen))
      viol <= viol + 1;
    if (M_REQ) req_hi <= req_hi + 1;
    prev_req   <= M_REQ;
    prev_addr  <= M_ADDR;
    prev_wdata <= M_WDATA;
    prev_wen   <= M_WEN;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [31:0] e, o;
    chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_write"}, o, e);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic push_writes(input logic [15:0] base, input logic [15:0] cnt,
                             input logic [15:0] seed);
    for (int k = 0; k < int'(cnt); k++)
      exp_q.push_back({base + 16'(2 * k), seed + 16'(k)});
  endtask

  // Issues one command; lat = cycles from the accepting edge to DONE
  // (0 if DONE never came). A START with junk parameters is pulsed at
  // cycle 'mid' when mid > 0.
  task automatic run_cmd(input logic op, input logic [15:0] base, input logic [15:0] cnt,
                         input logic [15:0] seed, input int mid,
                         output int lat, output logic busy1);
    @(negedge CLK);
    START = 1'b1; OP = op; BASE = base; COUNT = cnt; SEED = seed;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = 0;
    busy1 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c == mid) begin
        START = 1'b1; OP = 1'b1; BASE = 16'h0400; COUNT = 16'd10; SEED = 16'hDEAD;
      end else begin
        START = 1'b0;
      end
      if (c == 1) busy1 = BUSY;
      if (DONE) begin
        lat = c;
        break;
      end
      @(posedge CLK); #1;
    end
    START = 1'b0;
  endtask

  typedef struct {
    logic        op;
    logic [15:0] base;
    logic [15:0] count;
    logic [15:0] seed;
    int          mid;
    int          lat;
    logic [15:0] err;
    logic [15:0] first;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat, r0, h0;
    logic busy1;
    logic done_seen;
    string tag;

    vecs[0]  = '{1'b1, 16'h0100, 16'd4, 16'hA000, 0, 17, 16'd0, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0100, 16'd4, 16'hA000, 0, 17, 16'd0, 16'h0000};
    vecs[2]  = '{1'b0, 16'h0100, 16'd4, 16'hA001, 0, 17, 16'd4, 16'h0100};
    vecs[3]  = '{1'b1, 16'h1000, 16'd0, 16'h0001, 0,  1, 16'd0, 16'h0000};
    vecs[4]  = '{1'b0, 16'h1000, 16'd0, 16'h0001, 0,  1, 16'd0, 16'h0000};
    vecs[5]  = '{1'b1, 16'hFFFE, 16'd2, 16'h1234, 0,  9, 16'd0, 16'h0000};
    vecs[6]  = '{1'b0, 16'hFFFE, 16'd2, 16'h1234, 0,  9, 16'd0, 16'h0000};
    vecs[7]  = '{1'b0, 16'h00FE, 16'd3, 16'hA000, 0, 13, 16'd3, 16'h00FE};
    vecs[8]  = '{1'b1, 16'h0200, 16'd3, 16'hFFFF, 0, 13, 16'd0, 16'h0000};
    vecs[9]  = '{1'b0, 16'h0202, 16'd2, 16'h0000, 0,  9, 16'd0, 16'h0000};
    vecs[10] = '{1'b1, 16'h0300, 16'd3, 16'h5000, 3, 13, 16'd0, 16'h0000};
    vecs[11] = '{1'b0, 16'h0300, 16'd3, 16'h5000, 0, 13, 16'd0, 16'h0000};
    vecs[12] = '{1'b0, 16'hFFFE, 16'd1, 16'h1233, 0,  5, 16'd1, 16'hFFFE};

    nRST = 1'b0; START = 1'b0; OP = 1'b0; BASE = '0; COUNT = '0; SEED = '0;
    mem_mode = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_req",   M_REQ, 0);
    chk("reset_wen",   M_WEN, 0);
    chk("reset_addr",  M_ADDR, 0);
    chk("reset_wdata", M_WDATA, 0);
    chk("reset_flags", {BUSY, DONE, TIMEOUT_ERR}, 0);
    chk("reset_err",   {ERR_CNT, FIRST_ERR_ADDR}, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // ---------------- table-driven bursts ----------------
    for (int i = 0; i < 13; i++) begin
      tag = $sformatf("v%0d", i);
      if (vecs[i].op) push_writes(vecs[i].base, vecs[i].count, vecs[i].seed);
      r0 = req_rises;
      run_cmd(vecs[i].op, vecs[i].base, vecs[i].count, vecs[i].seed, vecs[i].mid, lat, busy1);
      chk({tag, "_latency"}, lat, vecs[i].lat);
      chk({tag, "_busy1"},   busy1, (vecs[i].count != 0) ? 1 : 0);
      chk({tag, "_busy_at_done"}, BUSY, 0);
      chk({tag, "_err_cnt"}, ERR_CNT, vecs[i].err);
      chk({tag, "_first"},   FIRST_ERR_ADDR, vecs[i].first);
      chk({tag, "_tmo"},     TIMEOUT_ERR, 0);
      @(posedge CLK); #1;
      chk({tag, "_done_pulse"}, DONE, 0);
      chk({tag, "_req_count"}, req_rises - r0, vecs[i].count);
      check_writes(tag);
    end

    chk("mem_0100", mem[15'h0080], 16'hA000);
    chk("mem_0102", mem[15'h0081], 16'hA001);
    chk("mem_0104", mem[15'h0082], 16'hA002);
    chk("mem_0106", mem[15'h0083], 16'hA003);
    chk("mem_FFFE", mem[15'h7FFF], 16'h1234);
    chk("mem_0000", mem[15'h0000], 16'h1235);
    chk("mem_0400_untouched", mem[15'h0200], 16'h0000);

    // ---------------- timeout: ACK never rises ----------------
    mem_mode = 1;
    r0 = req_rises; h0 = req_hi;
    run_cmd(1'b1, 16'h0500, 16'd3, 16'h0000, 0, lat, busy1);
    chk("tmo1_latency", lat, TMO + 1);
    chk("tmo1_flag", TIMEOUT_ERR, 1);
    chk("tmo1_req_low", M_REQ, 0);
    @(posedge CLK); #1;
    chk("tmo1_done_pulse", DONE, 0);
    chk("tmo1_req_hi_cycles", req_hi - h0, TMO);
    chk("tmo1_req_count", req_rises - r0, 1);
    check_writes("tmo1");
    mem_mode = 0;

    // ---------------- timeout: ACK stuck high after word 0 ----------------
    mem_mode = 2;
    exp_q.push_back({16'h0500, 16'h4444});
    r0 = req_rises; h0 = req_hi;
    run_cmd(1'b1, 16'h0500, 16'd3, 16'h4444, 0, lat, busy1);
    chk("tmo2_latency", lat, TMO + 3);
    chk("tmo2_flag", TIMEOUT_ERR, 1);
    @(posedge CLK); #1;
    chk("tmo2_req_hi_cycles", req_hi - h0, 2);
    chk("tmo2_req_count", req_rises - r0, 1);
    check_writes("tmo2");
    mem_mode = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("tmo2_sticky", TIMEOUT_ERR, 1);

    // ---------------- reset during word 2 of 4 ----------------
    push_writes(16'h0600, 16'd2, 16'h7000);
    @(negedge CLK);
    START = 1'b1; OP = 1'b1; BASE = 16'h0600; COUNT = 16'd4; SEED = 16'h7000;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    nRST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_req",   M_REQ, 0);
    chk("rst_wen",   M_WEN, 0);
    chk("rst_addr",  M_ADDR, 0);
    chk("rst_wdata", M_WDATA, 0);
    chk("rst_flags", {BUSY, DONE, TIMEOUT_ERR}, 0);
    chk("rst_err",   {ERR_CNT, FIRST_ERR_ADDR}, 0);
    nRST = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      done_seen = done_seen | DONE;
    end
    chk("rst_no_done", done_seen, 0);
    check_writes("rst");

    push_writes(16'h0600, 16'd4, 16'h7000);
    run_cmd(1'b1, 16'h0600, 16'd4, 16'h7000, 0, lat, busy1);
    chk("post_rst_latency", lat, 17);
    chk("post_rst_tmo", TIMEOUT_ERR, 0);
    @(posedge CLK); #1;
    check_writes("post_rst");
    run_cmd(1'b0, 16'h0600, 16'd4, 16'h7000, 0, lat, busy1);
    chk("post_rst_verify_lat", lat, 17);
    chk("post_rst_verify_err", ERR_CNT, 0);

    chk("handshake_protocol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_test_master.md
# mem_test_master

Built-in test master that drives the 16-bit word memory port through its 4-phase REQ/ACK handshake. On a START command it runs a burst of COUNT word accesses at stride 2 from BASE. In write mode it fills memory with an incrementing pattern. In verify mode it reads the same pattern back, counts mismatches and records the first failing address. It sits directly upstream of the memory, in place of the testbench `top` driver, and owns ADDR/DIN/REQ/WEN into it.

## Interface
- TIMEOUT, 255: max cycles spent waiting for any single ACK edge before abort (≥1).
- CLK  in  1  clock, all logic on posedge.
- nRST  in  1  reset, synchronous, active-low.
- START  in  1  command strobe, sampled only in IDLE.
- OP  in  1  1 = write burst, 0 = verify burst.
- BASE  in  16  byte address of word 0.
- COUNT  in  16  number of words; 0 = no-op.
- SEED  in  16  data for word 0.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse at burst end (normal or abort).
- ERR_CNT  out  16  verify mismatch count, saturates at 16'hFFFF.
- FIRST_ERR_ADDR  out  16  address of first mismatch; 0 if none.
- TIMEOUT_ERR  out  1  set on handshake timeout, sticky until next START.
- M_ADDR  out  16  memory address.
- M_WDATA  out  16  write data to memory.
- M_RDATA  in  16  read data from memory.
- M_REQ  out  1  request.
- M_WEN  out  1  1 = write.
- M_ACK  in  1  acknowledge.

## Operation
- Word k (0 ≤ k < COUNT): address = BASE + 2k mod 2^16 (wraps at 16'hFFFE→16'h0000); data = SEED + k mod 2^16.
- BASE/COUNT/SEED/OP are latched on START accept; later input changes have no effect mid-burst.
- FSM states:
  - IDLE: on START, latch command and clear ERR_CNT, FIRST_ERR_ADDR, TIMEOUT_ERR. If COUNT = 0 go to FIN, else go to ASSERT.
  - ASSERT: M_REQ = 1. M_ADDR, M_WDATA and M_WEN are stable for the whole state. On M_ACK = 1: in verify mode, compare M_RDATA with expected, then go to RELEASE.
  - RELEASE: M_REQ = 0. On M_ACK = 0: if k = COUNT-1 go to FIN, else k++ and go to ASSERT.
  - FIN: DONE = 1 for one cycle, BUSY = 0, go to IDLE.
- Mismatch handling: ERR_CNT increments, saturating. On the first mismatch only, FIRST_ERR_ADDR is loaded with the current address.
- Timeout: a wait counter clears on every state entry and increments each cycle in ASSERT/RELEASE. When it reaches TIMEOUT, force M_REQ = 0, set TIMEOUT_ERR and go to FIN. Remaining words are skipped.
- START while BUSY is ignored, with no queueing.
- Reset values: M_REQ=0, M_WEN=0, M_ADDR=0, M_WDATA=0, BUSY=0, DONE=0, ERR_CNT=0, FIRST_ERR_ADDR=0, TIMEOUT_ERR=0, state IDLE, k=0.
- Reset mid-burst: abandon immediately. No DONE pulse. The memory is also reset, so no half-open handshake remains.

## Timing
- All outputs are registered. M_REQ rises in the cycle after the edge that accepts START, with M_ADDR/M_WDATA/M_WEN valid in that same cycle.
- M_RDATA is sampled on the same edge where M_ACK is first seen high. The memory updates read data on the same edge it raises ACK, so this data is valid.
- Against the memory, each word takes 4 cycles:
  - edge E0: M_REQ goes high.
  - E1: memory samples the request, ACK goes high.
  - E2: master sees ACK, M_REQ goes low.
  - E3: memory sees REQ low, ACK goes low.
  - E4: master sees ACK low, next M_REQ goes high.
- An N-word burst therefore raises DONE 4N+1 cycles after START acceptance, and M_REQ is never high while M_ACK is still high from the previous word.
- COUNT = 0: DONE pulses the cycle after acceptance, M_REQ stays 0.
- BUSY falls in the DONE cycle. A new START is accepted from the cycle after DONE.

## Test plan
- Write burst: OP=1, BASE=16'h0100, COUNT=4, SEED=16'hA000 → memory bytes 0x0100..0x0107 = A0 00 A0 01 A0 02 A0 03; DONE 17 cycles after accept; ERR_CNT=0.
- Verify after write: same command with OP=0 → ERR_CNT=0, FIRST_ERR_ADDR=0, TIMEOUT_ERR=0. Repeat with SEED=16'hA001 → ERR_CNT=4, FIRST_ERR_ADDR=16'h0100.
- COUNT=0 and busy START: COUNT=0 → DONE next cycle, no M_REQ pulse. START pulsed mid-burst → ignored, burst length unchanged.
- Address wrap (memory model covering the full 64 KB): BASE=16'hFFFE, COUNT=2, OP=1 → writes at 16'hFFFE then 16'h0000.
- Timeout: memory model holding ACK=0, TIMEOUT=8 → M_REQ high 8 cycles then low, TIMEOUT_ERR=1, DONE pulse. Second case: ACK stuck high after first word → abort in RELEASE.
- Reset mid-burst: nRST=0 for 1 cycle during word 2 of 4 → all outputs at reset values next cycle, no DONE. A fresh START then completes normally.
